fpadd_seq: RTL and testbench
============================

// Module: fpadd_seq
// PURPOSE
//  Multi-cycle IEEE-754 single-precision adder with valid/ready handshakes on both sides.
//  Arithmetic result is bit-identical to the combinational fpadd for all supported inputs.
//  Serves as the clocked datapath unit of the ALU and as the responder driven by vector-based benches.
//  Rounding is truncation (round toward zero). Denormal inputs and outputs flush to zero.
// PARAMETERS
//  ALIGN_STEP  1  max bits the smaller mantissa is right-shifted per ALIGN cycle (1..8)
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  reset      in   1   synchronous, active-high; ignores a, b and in_valid while high
//  a, b       in   32  operands {sign, exp[7:0], frac[22:0]}; sampled only on input handshake
//  in_valid   in   1   operands valid
//  in_ready   out  1   high only in IDLE; reset value 0
//  s          out  32  result; reset value 0; stable while out_valid=1
//  out_valid  out  1   result valid; reset value 0
//  out_ready  in   1   consumer accepts s
// BEHAVIOUR
//  Input handshake: in_valid & in_ready at a posedge. Output handshake: out_valid & out_ready at a posedge.
//  FSM states and transitions:
//   IDLE -> ALIGN on input handshake.
//   ALIGN -> ALIGN while rem > 0; -> ADD when rem == 0.
//   ADD -> NORM.
//   NORM -> NORM or DONE.
//   DONE -> IDLE on output handshake.
//  Reset (also mid-operation): state=IDLE, out_valid=0, s=0, in_ready=0; any in-flight op is discarded.
//  Capture (IDLE handshake):
//   exp==0 is treated as zero. Operands are swapped so that X has the larger {exp,frac}.
//   d = eX - eY; mantissas mX, mY = {1,frac} (24 bit); rem = d.
//  Fast path (capture -> DONE directly; out_valid 1 cycle after accept):
//   either exp==255 -> s = 32'h7FC0_0000 (no inf/NaN arithmetic);
//   an operand is zero -> s = the other operand (both zero -> 32'h0);
//   d >= 25 -> s = X unchanged.
//  ALIGN: mY >>= min(ALIGN_STEP, rem); rem -= that amount. Shifted-out bits are discarded.
//  ADD (one cycle): sum[24:0] = equal signs ? mX + mY : mX - mY (mX >= mY guaranteed).
//   Result sign = sign of X; result exponent e = eX.
//  NORM (evaluated each cycle):
//   sum==0 -> s = +0, go DONE.
//   sum[24] -> sum >>= 1, e += 1; if e == 255 then s = {sign, 8'hFF, 23'h0}; go DONE.
//   sum[23] -> s = {sign, e, sum[22:0]}, go DONE.
//   else if e == 1 -> s = {sign, 31'h0} (underflow flush), go DONE.
//   else sum <<= 1, e -= 1, stay in NORM.
//  Latency: accept -> out_valid = 3 + ceil(d/ALIGN_STEP) + (left-shift count), minimum 3.
//  out_valid is held, with s constant, until out_ready. in_ready stays 0 from accept until the DONE handshake.
//  out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
//  No combinational path from any input to any output.
// STRUCTURE
//  fpadd_pkg holds: fp32_t packed struct {sign, exp, frac}; state_t enum {IDLE, ALIGN, ADD, NORM, DONE};
//   constants QNAN=32'h7FC0_0000, EXP_INF=8'hFF, MANT_W=24.
//  Sub-module fpadd_unpack (combinational): zero/special detection, magnitude compare, swap, d computation.
//  FSM and datapath registers stay in fpadd_seq.
// TESTING (ALIGN_STEP=1; out_ready=1 unless stated; latency counted from accept edge)
//  3F800000 + 3F800000 -> s=40000000, out_valid after 3 cycles (NORM right-shift).
//  3FC00000 + BF800000 -> s=3F000000 (one left shift); 40400000 + C0400000 -> s=00000000.
//  3F800000 + 33800000 (d=24) -> s=3F800000 after 27 cycles; 3F800000 + 33000000 (d=25) -> s=3F800000 after 1 cycle.
//  7F7FFFFF + 7F7FFFFF -> s=7F800000; 7FC00000 + 3F800000 -> s=7FC00000 after 1 cycle.
//  Hold out_ready=0 for 5 cycles in DONE: s and out_valid stable, in_ready=0; a new in_valid is not accepted.
//  Assert reset during ALIGN of a d=24 op: next cycle out_valid=0, s=0, in_ready=0; after release, a
//   back-to-back 3F800000+3F800000 returns 40000000.

Source files
------------

// File: rtl/fpadd_pkg.sv
// Shared types and constants for the sequential single-precision adder.
package fpadd_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_INF = 8'hFF;
  localparam int          MANT_W  = 24;

endpackage

// File: rtl/fpadd_unpack.sv
// Operand classification, magnitude ordering and exponent difference.
module fpadd_unpack
  import fpadd_pkg::*;
(
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  output logic              fast,
  output logic [31:0]       fast_s,
  output logic              sign,
  output logic              sub,
  output logic [7:0]        ex,
  output logic [7:0]        d,
  output logic [MANT_W-1:0] mx,
  output logic [MANT_W-1:0] my
);

  fp32_t fa, fb, fx, fy;
  logic  a_zero, b_zero, swap;

  always_comb begin
    fa     = a;
    fb     = b;
    a_zero = (fa.exp == 8'd0);
    b_zero = (fb.exp == 8'd0);
    swap   = (b[30:0] > a[30:0]);
    fx     = swap ? fb : fa;
    fy     = swap ? fa : fb;
    d      = fx.exp - fy.exp;
    sign   = fx.sign;
    sub    = fx.sign ^ fy.sign;
    ex     = fx.exp;
    mx     = {1'b1, fx.frac};
    my     = {1'b1, fy.frac};

    // Specials win over zeros; zeros win over the too-far-apart case.
    fast   = 1'b1;
    fast_s = 32'h0;
    if (fa.exp == EXP_INF || fb.exp == EXP_INF) begin
      fast_s = QNAN;
    end else if (a_zero && b_zero) begin
      fast_s = 32'h0;
    end else if (a_zero) begin
      fast_s = b;
    end else if (b_zero) begin
      fast_s = a;
    end else if (d >= 8'd25) begin
      fast_s = fx;
    end else begin
      fast = 1'b0;
    end
  end

endmodule

// File: rtl/fpadd_seq.sv
// Multi-cycle truncating fp32 adder: shift-per-cycle alignment, one-cycle add, bit-serial normalize.
module fpadd_seq
  import fpadd_pkg::*;
#(
  parameter int ALIGN_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] s,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [7:0] STEP8 = 8'(ALIGN_STEP);

  state_t              state_reg, state_next;
  logic                fast_reg, fast_next;
  logic                sign_reg, sign_next;
  logic                sub_reg, sub_next;
  logic [7:0]          e_reg, e_next;
  logic [7:0]          rem_reg, rem_next;
  logic [MANT_W-1:0]   mx_reg, mx_next;
  logic [MANT_W-1:0]   my_reg, my_next;
  logic [MANT_W:0]     sum_reg, sum_next;
  logic [31:0]         s_reg, s_next;
  logic                out_valid_reg, in_ready_reg;

  logic                u_fast, u_sign, u_sub;
  logic [31:0]         u_fast_s;
  logic [7:0]          u_ex, u_d;
  logic [MANT_W-1:0]   u_mx, u_my;
  logic [7:0]          shamt, e_up;
  logic                in_hs;

  fpadd_unpack u_unpack (
    .a      (a),
    .b      (b),
    .fast   (u_fast),
    .fast_s (u_fast_s),
    .sign   (u_sign),
    .sub    (u_sub),
    .ex     (u_ex),
    .d      (u_d),
    .mx     (u_mx),
    .my     (u_my)
  );

  assign in_hs = in_valid && in_ready_reg;
  assign shamt = (rem_reg < STEP8) ? rem_reg : STEP8;
  assign e_up  = e_reg + 8'd1;

  always_comb begin
    state_next = state_reg;
    fast_next  = fast_reg;
    sign_next  = sign_reg;
    sub_next   = sub_reg;
    e_next     = e_reg;
    rem_next   = rem_reg;
    mx_next    = mx_reg;
    my_next    = my_reg;
    sum_next   = sum_reg;
    s_next     = s_reg;
    case (state_reg)
      IDLE: begin
        if (in_hs) begin
          // Fast results still spend one ALIGN cycle so out_valid rises one cycle after accept.
          fast_next  = u_fast;
          sign_next  = u_sign;
          sub_next   = u_sub;
          e_next     = u_ex;
          mx_next    = u_mx;
          my_next    = u_my;
          rem_next   = u_d;
          state_next = ALIGN;
          if (u_fast) begin
            s_next = u_fast_s;
          end
        end
      end
      ALIGN: begin
        if (fast_reg) begin
          state_next = DONE;
        end else if (rem_reg == 8'd0) begin
          state_next = ADD;
        end else begin
          my_next  = my_reg >> shamt;
          rem_next = rem_reg - shamt;
        end
      end
      ADD: begin
        sum_next   = sub_reg ? ({1'b0, mx_reg} - {1'b0, my_reg})
                             : ({1'b0, mx_reg} + {1'b0, my_reg});
        state_next = NORM;
      end
      NORM: begin
        if (sum_reg == '0) begin
          s_next     = 32'h0;
          state_next = DONE;
        end else if (sum_reg[MANT_W]) begin
          s_next     = (e_up == EXP_INF) ? {sign_reg, EXP_INF, 23'h0}
                                         : {sign_reg, e_up, sum_reg[23:1]};
          state_next = DONE;
        end else if (sum_reg[MANT_W-1]) begin
          s_next     = {sign_reg, e_reg, sum_reg[22:0]};
          state_next = DONE;
        end else if (e_reg == 8'd1) begin
          s_next     = {sign_reg, 31'h0};
          state_next = DONE;
        end else begin
          sum_next = sum_reg << 1;
          e_next   = e_reg - 8'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      fast_reg      <= 1'b0;
      sign_reg      <= 1'b0;
      sub_reg       <= 1'b0;
      e_reg         <= 8'd0;
      rem_reg       <= 8'd0;
      mx_reg        <= '0;
      my_reg        <= '0;
      sum_reg       <= '0;
      s_reg         <= 32'h0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fast_reg      <= fast_next;
      sign_reg      <= sign_next;
      sub_reg       <= sub_next;
      e_reg         <= e_next;
      rem_reg       <= rem_next;
      mx_reg        <= mx_next;
      my_reg        <= my_next;
      sum_reg       <= sum_next;
      s_reg         <= s_next;
      out_valid_reg <= (state_next == DONE);
      in_ready_reg  <= (state_next == IDLE);
    end
  end

  assign s         = s_reg;
  assign out_valid = out_valid_reg;
  assign in_ready  = in_ready_reg;

endmodule

// File: tb/tb_fpadd_seq.sv
// Self-checking bench for fpadd_seq: directed cases plus randomized operands against a reference model.
module tb_fpadd_seq;

  localparam int STEP = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] s;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  fpadd_seq #(.ALIGN_STEP(STEP)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: exact alignment by d, integer add, then normalize by the rounding/flush rules.
  function automatic void ref_add(input logic [31:0] ta, input logic [31:0] tb,
                                  output logic [31:0] rs, output int rlat);
    logic [31:0] x, y;
    int          d, e;
    longint      mx, my, sum;
    rlat = 1;
    if (ta[30:23] == 8'hFF || tb[30:23] == 8'hFF) begin
      rs = 32'h7FC0_0000;
      return;
    end
    if (ta[30:23] == 8'h00 && tb[30:23] == 8'h00) begin rs = 32'h0; return; end
    if (ta[30:23] == 8'h00) begin rs = tb; return; end
    if (tb[30:23] == 8'h00) begin rs = ta; return; end
    x = (ta[30:0] >= tb[30:0]) ? ta : tb;
    y = (ta[30:0] >= tb[30:0]) ? tb : ta;
    d = int'(x[30:23]) - int'(y[30:23]);
    if (d >= 25) begin rs = x; return; end
    mx   = longint'({1'b1, x[22:0]});
    my   = longint'({1'b1, y[22:0]}) >> d;
    sum  = (x[31] == y[31]) ? mx + my : mx - my;
    e    = int'(x[30:23]);
    rlat = 3 + (d + STEP - 1) / STEP;
    if (sum == 0) begin
      rs = 32'h0;
    end else if (sum >= 64'd16777216) begin
      sum = sum >> 1;
      e   = e + 1;
      rs  = (e == 255) ? {x[31], 8'hFF, 23'h0} : {x[31], 8'(e), 23'(sum)};
    end else begin
      while (sum < 64'd8388608 && e > 1) begin
        sum  = sum << 1;
        e    = e - 1;
        rlat = rlat + 1;
      end
      rs = (sum < 64'd8388608) ? {x[31], 31'h0} : {x[31], 8'(e), 23'(sum)};
    end
  endfunction

  // Present operands and return just after the accepting posedge.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb);
    int waited = 0;
    @(negedge clk);
    a = ta; b = tb; in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_int("accept_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count clock edges after the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb,
                       input logic [31:0] exp_s, input int exp_lat, input string tag);
    int lat;
    start_op(ta, tb);
    wait_out(lat);
    check32({tag, "_s"}, s, exp_s);
    check_int({tag, "_lat"}, lat, exp_lat);
    @(negedge clk);
    check_int({tag, "_ovdrop"}, int'(out_valid), 0);
    $display("op %s: %08h + %08h -> %08h latency %0d", tag, ta, tb, s, lat);
  endtask

  initial begin
    logic [31:0] ra, rb, rs;
    int          rlat, lat;
    int          ea, eb;
    reset = 1'b1; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_int("reset_out_valid", int'(out_valid), 0);
    check32("reset_s", s, 32'h0);
    check_int("reset_in_ready", int'(in_ready), 0);
    reset = 1'b0;

    do_op(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3,  "one_plus_one");
    do_op(32'h3FC0_0000, 32'hBF80_0000, 32'h3F00_0000, 4,  "left_shift");
    do_op(32'h4040_0000, 32'hC040_0000, 32'h0000_0000, 3,  "cancel");
    do_op(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 27, "d24");
    do_op(32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000, 1,  "d25");
    do_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 3,  "overflow");
    do_op(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1,  "nan_in");
    do_op(32'h0000_0000, 32'hC0A0_0000, 32'hC0A0_0000, 1,  "zero_a");
    do_op(32'h0080_0001, 32'h8080_0000, 32'h0000_0000, 3,  "underflow");

    // Consumer stalls: result must hold and a new request must be ignored.
    out_ready = 1'b0;
    start_op(32'h3FC0_0000, 32'h3F80_0000);
    wait_out(lat);
    check32("hold_first_s", s, 32'h4020_0000);
    for (int i = 0; i < 5; i++) begin
      a = 32'h3F80_0000; b = 32'h3F80_0000; in_valid = 1'b1;
      @(negedge clk);
      check_int("hold_out_valid", int'(out_valid), 1);
      check32("hold_s", s, 32'h4020_0000);
      check_int("hold_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_int("hold_release_ov", int'(out_valid), 0);
    repeat (4) @(negedge clk);
    check_int("hold_no_ghost", int'(out_valid), 0);
    $display("op hold: result 40200000 held 5 cycles, stray request ignored");

    // Reset in the middle of a long alignment.
    start_op(32'h3F80_0000, 32'h3380_0000);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_int("midreset_out_valid", int'(out_valid), 0);
    check32("midreset_s", s, 32'h0);
    check_int("midreset_in_ready", int'(in_ready), 0);
    reset = 1'b0;
    $display("op midreset: in-flight op discarded");
    do_op(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3, "after_reset");

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      ea = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 255)
                                       : int'($urandom_range(1, 254));
      eb = ea + int'($urandom_range(0, 60)) - 30;
      if (eb < 1) eb = 1;
      if (eb > 254) eb = 254;
      if ($urandom_range(0, 7) == 0) eb = ea;
      ra[30:23] = 8'(ea);
      rb[30:23] = 8'(eb);
      ref_add(ra, rb, rs, rlat);
      do_op(ra, rb, rs, rlat, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
